pkencode_t1: RTL and testbench

// Packs the t1 public-key polynomials (K x N coefficients, 10 significant bits each) from internal memory into
// 80-bit API words for the public-key output buffer. This is the encode-side counterpart of the t1 decode stage.

---
 rtl/pkencode_t1.sv | 171 +++++++++++++++++
 tb/tb_pkencode_t1.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkencode_t1.sv
// rtl/pkencode_t1.sv - t1 public-key encoder: packs 10-bit coefficients from memory into 80-bit API words
package pkencode_t1_pkg;
   localparam int ABR_MEM_ADDR_WIDTH = 15;

   typedef enum logic [1:0] {
      RW_IDLE  = 2'b00,
      RW_READ  = 2'b01,
      RW_WRITE = 2'b10
   } rw_mode_e;

   typedef struct packed {
      rw_mode_e                        rd_wr_en;
      logic [ABR_MEM_ADDR_WIDTH-1:0]   addr;
   } mem_if_t;
endpackage

module pkencode_t1
   import pkencode_t1_pkg::*;
#(
   parameter int MLDSA_K        = 8,
   parameter int MLDSA_N        = 256,
   parameter int REG_SIZE       = 24,
   parameter int COEFF_WIDTH    = 10,
   parameter int API_ADDR_WIDTH = 16
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 zeroize,
   input  logic                                 pkencode_enable,
   input  logic [ABR_MEM_ADDR_WIDTH-1:0]        src_base_addr,
   output mem_if_t                              mem_a_rd_req,
   output mem_if_t                              mem_b_rd_req,
   input  logic [3:0][REG_SIZE-1:0]             mem_a_rd_data,
   input  logic [3:0][REG_SIZE-1:0]             mem_b_rd_data,
   output logic [API_ADDR_WIDTH-1:0]            API_wr_address,
   output logic [8*COEFF_WIDTH-1:0]             API_wr_data,
   output logic                                 API_wr_en,
   output logic                                 pkencode_done,
   output logic                                 pkencode_error
);

   localparam int NUM_WORDS = MLDSA_K * MLDSA_N / 8;
   localparam int CNT_W     = $clog2(NUM_WORDS) + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_FLUSH,
      ST_DONE
   } state_e;

   state_e                          state_q, state_d;
   logic [CNT_W-1:0]                rd_cnt_q;
   logic [CNT_W-1:0]                wr_cnt_q;
   logic                            flush_cnt_q;
   logic [ABR_MEM_ADDR_WIDTH-1:0]   base_q;
   logic                            req_valid_q;
   logic                            data_valid_q;
   logic                            start;
   logic [ABR_MEM_ADDR_WIDTH-1:0]   addr_a;
   logic [8*COEFF_WIDTH-1:0]        packed_word;
   logic                            range_err;

   assign start  = (state_q == ST_IDLE) && pkencode_enable && !zeroize;
   assign addr_a = base_q + ABR_MEM_ADDR_WIDTH'({rd_cnt_q, 1'b0});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (pkencode_enable) state_d = ST_READ;
         ST_READ:  if (rd_cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = ST_FLUSH;
         ST_FLUSH: if (flush_cnt_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (zeroize) state_d = ST_IDLE;
   end

   // Lane i lands at bits [10*i +: 10]; anything above the packed width is a range violation.
   always_comb begin
      packed_word = '0;
      range_err   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         packed_word[COEFF_WIDTH*i     +: COEFF_WIDTH] = mem_a_rd_data[i][COEFF_WIDTH-1:0];
         packed_word[COEFF_WIDTH*(i+4) +: COEFF_WIDTH] = mem_b_rd_data[i][COEFF_WIDTH-1:0];
         range_err = range_err
                   | (|mem_a_rd_data[i][REG_SIZE-1:COEFF_WIDTH])
                   | (|mem_b_rd_data[i][REG_SIZE-1:COEFF_WIDTH]);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt_q       <= '0;
         wr_cnt_q       <= '0;
         flush_cnt_q    <= 1'b0;
         base_q         <= '0;
         req_valid_q    <= 1'b0;
         data_valid_q   <= 1'b0;
         mem_a_rd_req   <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_b_rd_req   <= '{rd_wr_en: RW_IDLE, addr: '0};
         API_wr_address <= '0;
         API_wr_data    <= '0;
         API_wr_en      <= 1'b0;
         pkencode_done  <= 1'b0;
         pkencode_error <= 1'b0;
      end else if (zeroize) begin
         rd_cnt_q       <= '0;
         wr_cnt_q       <= '0;
         flush_cnt_q    <= 1'b0;
         base_q         <= '0;
         req_valid_q    <= 1'b0;
         data_valid_q   <= 1'b0;
         mem_a_rd_req   <= '{rd_wr_en: RW_IDLE, addr: '0};
         mem_b_rd_req   <= '{rd_wr_en: RW_IDLE, addr: '0};
         API_wr_address <= '0;
         API_wr_data    <= '0;
         API_wr_en      <= 1'b0;
         pkencode_done  <= 1'b0;
         pkencode_error <= 1'b0;
      end else begin
         flush_cnt_q <= (state_q == ST_FLUSH) ? ~flush_cnt_q : 1'b0;

         if (start) begin
            base_q   <= src_base_addr;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
         end

         if (state_q == ST_READ) begin
            mem_a_rd_req <= '{rd_wr_en: RW_READ, addr: addr_a};
            mem_b_rd_req <= '{rd_wr_en: RW_READ, addr: addr_a + ABR_MEM_ADDR_WIDTH'(1)};
            rd_cnt_q     <= rd_cnt_q + CNT_W'(1);
            req_valid_q  <= 1'b1;
         end else begin
            mem_a_rd_req <= '{rd_wr_en: RW_IDLE, addr: '0};
            mem_b_rd_req <= '{rd_wr_en: RW_IDLE, addr: '0};
            req_valid_q  <= 1'b0;
         end

         // Memory returns data one cycle after the request is visible.
         data_valid_q <= req_valid_q;
         API_wr_en    <= data_valid_q;
         if (data_valid_q) begin
            API_wr_data    <= packed_word;
            API_wr_address <= API_ADDR_WIDTH'(wr_cnt_q);
            wr_cnt_q       <= wr_cnt_q + CNT_W'(1);
         end else begin
            API_wr_data    <= '0;
            API_wr_address <= '0;
         end

         if (start) begin
            pkencode_error <= 1'b0;
         end else if (data_valid_q && range_err) begin
            pkencode_error <= 1'b1;
         end

         pkencode_done <= (state_q == ST_DONE);
      end
   end

endmodule

// File: tb/tb_pkencode_t1.sv
// tb/tb_pkencode_t1.sv - scoreboard bench for pkencode_t1 with a behavioural read memory
module tb_pkencode_t1;
   import pkencode_t1_pkg::*;

   localparam int NW = 256;
   localparam int AW = ABR_MEM_ADDR_WIDTH;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   zeroize = 1'b0;
   logic                   pkencode_enable = 1'b0;
   logic [AW-1:0]          src_base_addr = '0;
   mem_if_t                mem_a_rd_req, mem_b_rd_req;
   logic [3:0][23:0]       mem_a_rd_data, mem_b_rd_data;
   logic [15:0]            API_wr_address;
   logic [79:0]            API_wr_data;
   logic                   API_wr_en;
   logic                   pkencode_done;
   logic                   pkencode_error;

   pkencode_t1 dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .zeroize         (zeroize),
      .pkencode_enable (pkencode_enable),
      .src_base_addr   (src_base_addr),
      .mem_a_rd_req    (mem_a_rd_req),
      .mem_b_rd_req    (mem_b_rd_req),
      .mem_a_rd_data   (mem_a_rd_data),
      .mem_b_rd_data   (mem_b_rd_data),
      .API_wr_address  (API_wr_address),
      .API_wr_data     (API_wr_data),
      .API_wr_en       (API_wr_en),
      .pkencode_done   (pkencode_done),
      .pkencode_error  (pkencode_error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] addr;
      logic [79:0] data;
      bit          chk_err;
      bit          err;
   } exp_t;

   exp_t          sb_q[$];
   int            total = 0;
   int            bad = 0;
   int            n_wr = 0;
   int            n_rd = 0;
   int            n_done = 0;
   int            start_cyc = 0;
   int            last_wr_cyc = 0;
   logic [AW-1:0] exp_rd_addr = '0;

   bit            bad_en = 1'b0;
   logic [AW-1:0] bad_addr = '0;
   int            bad_lane = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Coefficient stored at address a, lane l is (4a+l) mod 1024, with one optional out-of-range value.
   function automatic logic [23:0] coeff(input logic [AW-1:0] a, input int l);
      if (bad_en && a == bad_addr && l == bad_lane) return 24'h000400;
      return 24'((int'(a) * 4 + l) % 1024);
   endfunction

   always @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         mem_a_rd_data[l] <= coeff(mem_a_rd_req.addr, l);
         mem_b_rd_data[l] <= coeff(mem_b_rd_req.addr, l);
      end
   end

   function automatic logic [79:0] exp_word(input logic [AW-1:0] base, input int j);
      logic [AW-1:0] aa, ab;
      logic [23:0]   c;
      logic [79:0]   w;
      aa = base + AW'(2 * j);
      ab = aa + AW'(1);
      w  = '0;
      for (int i = 0; i < 4; i++) begin
         c = coeff(aa, i);
         w[10*i +: 10] = c[9:0];
         c = coeff(ab, i);
         w[10*(i+4) +: 10] = c[9:0];
      end
      return w;
   endfunction

   task automatic push_run(input logic [AW-1:0] base, input int bad_word);
      exp_t e;
      for (int j = 0; j < NW; j++) begin
         e.addr    = 16'(j);
         e.data    = exp_word(base, j);
         e.chk_err = (bad_word < 0) || (j != bad_word);
         e.err     = (bad_word >= 0) && (j > bad_word);
         sb_q.push_back(e);
      end
   endtask

   // Monitor: writes against the scoreboard, read addresses against a running pointer, done timing.
   always @(negedge clk) begin
      exp_t e;
      if (API_wr_en) begin
         n_wr++;
         last_wr_cyc = cyc;
         if (sb_q.size() == 0) begin
            chk("unexpected_write", API_wr_en, 1'b0);
         end else begin
            e = sb_q.pop_front();
            chk("wr_addr", API_wr_address, e.addr);
            chk("wr_data", API_wr_data, e.data);
            if (e.chk_err) chk("err_during_run", pkencode_error, e.err);
         end
      end
      if (mem_a_rd_req.rd_wr_en == RW_READ) begin
         n_rd++;
         chk("rd_a_addr", mem_a_rd_req.addr, exp_rd_addr);
         chk("rd_b_req", mem_b_rd_req, {RW_READ, exp_rd_addr + AW'(1)});
         exp_rd_addr = exp_rd_addr + AW'(2);
      end else begin
         chk("rd_idle", {mem_a_rd_req, mem_b_rd_req}, '0);
      end
      if (pkencode_done) begin
         n_done++;
         chk("done_cycle", cyc - start_cyc + 1, 260);
         chk("done_after_last_wr", cyc - last_wr_cyc, 1);
      end
   end

   task automatic start_run(input logic [AW-1:0] base);
      @(negedge clk);
      src_base_addr   = base;
      pkencode_enable = 1'b1;
      exp_rd_addr     = base;
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      pkencode_enable = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pkencode_done) return;
      end
      chk("done_timeout", pkencode_done, 1'b1);
   endtask

   task automatic wait_cycle(input int n);
      for (int i = 0; i < 400 && (cyc - start_cyc + 1) < n; i++) @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_req_a"}, mem_a_rd_req, '0);
      chk({name, "_req_b"}, mem_b_rd_req, '0);
      chk({name, "_wr"}, {API_wr_en, API_wr_address, API_wr_data}, '0);
      chk({name, "_done_err"}, {pkencode_done, pkencode_error}, 2'b00);
   endtask

   initial begin
      int wr0, rd0, dn0;

      #22;
      chk_idle_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Plain run from 0x100: word 0 holds coefficients 7..0.
      wr0 = n_wr; rd0 = n_rd;
      push_run(15'h100, -1);
      sb_q[0].data = {10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1, 10'd0};
      start_run(15'h100);
      wait_done();
      @(negedge clk);
      chk("t1_writes", n_wr - wr0, NW);
      chk("t1_reads", n_rd - rd0, NW);
      chk("t1_sb_empty", sb_q.size(), 0);
      chk("t1_error", pkencode_error, 1'b0);
      chk("t1_last_rd_addr", exp_rd_addr, 15'h300);

      // Coefficient 37 out of range: lane 5 of word 4 is truncated to 0.
      bad_en = 1'b1; bad_addr = 15'h109; bad_lane = 1;
      wr0 = n_wr;
      push_run(15'h100, 4);
      sb_q[4].data = {10'd39, 10'd38, 10'd0, 10'd36, 10'd35, 10'd34, 10'd33, 10'd32};
      start_run(15'h100);
      wait_done();
      chk("t2_error_at_done", pkencode_error, 1'b1);
      @(negedge clk);
      chk("t2_error_sticky", pkencode_error, 1'b1);
      chk("t2_writes", n_wr - wr0, NW);
      bad_en = 1'b0;

      // Enable pulsed mid-run with a different base must be ignored.
      wr0 = n_wr;
      push_run(15'h100, -1);
      start_run(15'h100);
      wait_cycle(50);
      src_base_addr = 15'h400;
      pkencode_enable = 1'b1;
      @(negedge clk);
      pkencode_enable = 1'b0;
      chk("t3_error_cleared", pkencode_error, 1'b0);
      wait_done();
      @(negedge clk);
      chk("t3_writes", n_wr - wr0, NW);
      chk("t3_sb_empty", sb_q.size(), 0);

      // Zeroize at cycle 100 aborts a run that already flagged an error.
      bad_en = 1'b1;
      dn0 = n_done;
      push_run(15'h100, 4);
      start_run(15'h100);
      wait_cycle(100);
      chk("t4_error_before", pkencode_error, 1'b1);
      zeroize = 1'b1;
      @(posedge clk);
      #1 sb_q.delete();
      @(negedge clk);
      zeroize = 1'b0;
      chk_idle_outputs("t4_zeroize");
      wr0 = n_wr;
      repeat (300) @(negedge clk);
      chk("t4_no_done", n_done - dn0, 0);
      chk("t4_no_writes", n_wr - wr0, 0);
      bad_en = 1'b0;
      wr0 = n_wr;
      push_run(15'h200, -1);
      start_run(15'h200);
      wait_done();
      @(negedge clk);
      chk("t4_fresh_writes", n_wr - wr0, NW);

      // Asynchronous reset mid-READ clears everything including error.
      bad_en = 1'b1;
      push_run(15'h100, 4);
      start_run(15'h100);
      wait_cycle(100);
      #2 reset_n = 1'b0;
      #1 chk_idle_outputs("t5_async_reset");
      sb_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      bad_en = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_still_idle", {API_wr_en, mem_a_rd_req.rd_wr_en}, '0);

      // Back-to-back: errored run, then enable in the done cycle with a wrapping base.
      bad_en = 1'b1;
      wr0 = n_wr; dn0 = n_done;
      push_run(15'h100, 4);
      start_run(15'h100);
      wait_done();
      chk("t6_first_error", pkencode_error, 1'b1);
      bad_en = 1'b0;
      push_run(15'h7F80, -1);
      src_base_addr   = 15'h7F80;
      pkencode_enable = 1'b1;
      exp_rd_addr     = 15'h7F80;
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      pkencode_enable = 1'b0;
      wait_done();
      @(negedge clk);
      chk("t6_writes", n_wr - wr0, 2 * NW);
      chk("t6_dones", n_done - dn0, 2);
      chk("t6_error", pkencode_error, 1'b0);
      chk("t6_sb_empty", sb_q.size(), 0);
      chk("t6_wrapped_rd_addr", exp_rd_addr, 15'h0180);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
